// File: rtl/rsa_pkg.sv
// Shared constants and types for the 6-bit RSA datapath.
package rsa_pkg;

    // Default operand width for cipher, key, modulus and result.
    localparam int unsigned W_DEFAULT = 6;

    // Cycles from the accepting edge to the edge that raises done.
    localparam int unsigned LAT = 1 + 2 * W_DEFAULT * (2 * W_DEFAULT + 1);

    // Control states of the square-and-multiply sequencer.
    typedef enum logic [2:0] {
        StIdle,
        StSqIssue,
        StSqWait,
        StMulIssue,
        StMulWait,
        StFinish
    } state_e;

endpackage

// File: rtl/mod_reduce.sv
// Restoring shift-subtract reducer: rem = dividend mod modulus.
// Consumes one dividend bit per cycle, MSB first. The first bit is folded in
// on the launch edge, so done is high in the 2W-th cycle counting the
// launch cycle, and stays high for exactly one cycle.
module mod_reduce #(
    parameter int unsigned W = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           go,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   modulus,
    output logic           done,
    output logic [W-1:0]   rem
);

    localparam int unsigned CW = $clog2(2 * W + 1);
    localparam logic [CW-1:0] LAST = CW'(2 * W);

    logic [W-1:0]   r_q;
    logic [2*W-1:0] dvd_q;
    logic [W-1:0]   m_q;
    logic [CW-1:0]  cnt_q;
    logic           active_q;

    // One restoring step: shift in a bit, subtract the modulus if it fits.
    // r < m on entry, so the shifted value is below 2m and one subtract suffices.
    function automatic logic [W-1:0] step(input logic [W-1:0] r, input logic b,
                                          input logic [W-1:0] m);
        logic [W:0] t;
        t = {r, b};
        if (t >= {1'b0, m}) begin
            t = t - {1'b0, m};
        end
        return t[W-1:0];
    endfunction

    // Launch on go, then one step per cycle until all 2W bits are consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q      <= '0;
            dvd_q    <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (go) begin
            r_q      <= step('0, dividend[2*W-1], modulus);
            dvd_q    <= dividend << 1;
            m_q      <= modulus;
            cnt_q    <= CW'(1);
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == LAST) begin
                active_q <= 1'b0;
            end else begin
                r_q   <= step(r_q, dvd_q[2*W-1], m_q);
                dvd_q <= dvd_q << 1;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign done = active_q && (cnt_q == LAST);
    assign rem  = r_q;

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption: plain = cipher^priv_key mod n by left-to-right
// square-and-multiply. The multiply step runs for every key bit so the
// latency does not depend on the key.
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] cipher,
    input  logic [W-1:0] priv_key,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] plain
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] I_TOP = IW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  c_q, c_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  plain_q, plain_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic          busy_q, done_q;

    logic [W-1:0]  mul_b;
    logic [PW-1:0] prod;
    logic          red_go;
    logic          red_done;
    logic [W-1:0]  red_rem;

    // Single multiplier: squares acc, or multiplies acc by the captured cipher.
    always_comb begin
        mul_b = (state_q == StMulIssue) ? c_q : acc_q;
        prod  = PW'(acc_q) * PW'(mul_b);
    end

    assign red_go = (state_q == StSqIssue) || (state_q == StMulIssue);

    mod_reduce #(
        .W (W)
    ) u_mod_reduce (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (red_go),
        .dividend (prod),
        .modulus  (n_q),
        .done     (red_done),
        .rem      (red_rem)
    );

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        n_d     = n_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        err_d   = err_q;
        plain_d = plain_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    c_d   = cipher;
                    d_d   = priv_key;
                    n_d   = n;
                    idx_d = I_TOP;
                    err_d = 1'b0;
                    // Moduli 0 and 1 have no meaningful residue; report and skip.
                    if (n < W'(2)) begin
                        acc_d   = '0;
                        state_d = StFinish;
                    end else begin
                        acc_d   = W'(1);
                        state_d = StSqIssue;
                    end
                end
            end
            StSqIssue: state_d = StSqWait;
            StSqWait: begin
                if (red_done) begin
                    acc_d   = red_rem;
                    state_d = StMulIssue;
                end
            end
            StMulIssue: state_d = StMulWait;
            StMulWait: begin
                if (red_done) begin
                    // Product is always computed; only kept when the key bit is set.
                    if (d_q[idx_q]) begin
                        acc_d = red_rem;
                    end
                    if (idx_q == '0) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = StSqIssue;
                    end
                end
            end
            StFinish: begin
                plain_d = acc_q;
                err_d   = (n_q < W'(2));
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; busy and done trail the FSM by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            c_q     <= '0;
            d_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            plain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            plain_q <= plain_d;
            busy_q  <= (state_q != StIdle);
            done_q  <= (state_q == StFinish);
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign plain = plain_q;

endmodule

// File: tb/tb_rsa_decrypt.sv
// Self-checking bench for rsa_decrypt: directed table, corner sequences and
// a sweep of every modulus against a repeated-multiplication model.
module tb_rsa_decrypt;
    import rsa_pkg::*;

    localparam int W = W_DEFAULT;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] cipher = '0;
    logic [W-1:0] priv_key = '0;
    logic [W-1:0] n = '0;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] plain;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_last = '0;

    rsa_decrypt #(
        .W (W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .cipher   (cipher),
        .priv_key (priv_key),
        .n        (n),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .plain    (plain)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic [W-1:0] nn;
        logic [W-1:0] exp_plain;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model: C multiplied into 1 D times, reduced each time.
    function automatic logic [W-1:0] ref_pow(input int c, input int d, input int nn);
        int r;
        if (nn < 2) return '0;
        r = 1;
        for (int k = 0; k < d; k++) r = (r * c) % nn;
        return W'(r);
    endfunction

    // One transaction; optionally pulses start again 'poke' cycles in.
    task automatic run_op(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] nn,
                          input int poke, output logic [W-1:0] p, output logic e,
                          output int lat, output int bcnt, output int dones);
        @(negedge clk);
        cipher = c;
        priv_key = d;
        n = nn;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_at_accept", busy, 0);
        check("err_clear_on_accept", err, 0);
        check("plain_hold", plain, exp_last);
        lat = 0;
        bcnt = 0;
        dones = 0;
        p = '0;
        e = 1'b0;
        while (lat < 400 && dones == 0) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
            if (done) begin
                dones++;
                p = plain;
                e = err;
            end
            if (lat == poke) begin
                start = 1'b1;
                cipher = ~c;
                n = W'(35);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (dones == 0) check("done_timeout", 0, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            if (busy) bcnt++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] p, exp_p;
        logic e;
        int lat, bcnt, dones, t, first, second;

        vecs[0] = '{c: 6'd31, d: 6'd7, nn: 6'd33, exp_plain: 6'd4, exp_err: 1'b0, exp_lat: LAT};
        vecs[1] = '{c: 6'd20, d: 6'd0, nn: 6'd33, exp_plain: 6'd1, exp_err: 1'b0, exp_lat: LAT};
        vecs[2] = '{c: 6'd40, d: 6'd1, nn: 6'd33, exp_plain: 6'd7, exp_err: 1'b0, exp_lat: LAT};
        vecs[3] = '{c: 6'd5,  d: 6'd9, nn: 6'd1,  exp_plain: 6'd0, exp_err: 1'b1, exp_lat: 1};
        vecs[4] = '{c: 6'd17, d: 6'd3, nn: 6'd0,  exp_plain: 6'd0, exp_err: 1'b1, exp_lat: 1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_busy", busy, 0);
        check("reset_plain", plain, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].c, vecs[i].d, vecs[i].nn, 0, p, e, lat, bcnt, dones);
            check($sformatf("vec%0d_plain", i), p, vecs[i].exp_plain);
            check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_lat);
            check($sformatf("vec%0d_done_count", i), dones, 1);
            exp_last = vecs[i].exp_plain;
        end

        // Second start at cycle 50 must be ignored.
        run_op(6'd31, 6'd7, 6'd33, 50, p, e, lat, bcnt, dones);
        check("poke_plain", p, 4);
        check("poke_latency", lat, LAT);
        check("poke_done_count", dones, 1);
        check("poke_busy_cycles", bcnt, LAT);
        exp_last = 6'd4;

        // Back-to-back: start held high; inputs changed mid-run are taken only
        // at the second acceptance, in the first done cycle.
        @(negedge clk);
        cipher = 6'd31;
        priv_key = 6'd7;
        n = 6'd33;
        start = 1'b1;
        @(posedge clk);
        #1;
        t = 0;
        first = 0;
        second = 0;
        while (t < 700 && second == 0) begin
            @(posedge clk);
            #1;
            t++;
            if (t == 10) begin
                cipher = 6'd40;
                priv_key = 6'd1;
            end
            if (done) begin
                if (first == 0) begin
                    first = t;
                    check("b2b_first_plain", plain, 4);
                end else begin
                    second = t;
                    start = 1'b0;
                    check("b2b_second_plain", plain, 7);
                end
            end
        end
        start = 1'b0;
        check("b2b_first_at", first, LAT);
        check("b2b_second_at", second, 2 * LAT + 1);
        @(posedge clk);
        #1;
        check("b2b_idle_busy", busy, 0);
        exp_last = 6'd7;

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        cipher = 6'd31;
        priv_key = 6'd7;
        n = 6'd33;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        check("pre_reset_plain", plain, 7);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_err", err, 0);
        check("async_plain", plain, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("post_reset_quiet", dones, 0);
        exp_last = '0;
        run_op(6'd31, 6'd7, 6'd33, 0, p, e, lat, bcnt, dones);
        check("post_reset_plain", p, 4);
        check("post_reset_latency", lat, LAT);
        exp_last = 6'd4;

        // Sweep every legal modulus with random cipher and key.
        for (int nn = 2; nn < (1 << W); nn++) begin
            logic [W-1:0] rc, rd;
            rc = W'($urandom_range(0, (1 << W) - 1));
            rd = W'($urandom_range(0, (1 << W) - 1));
            exp_p = ref_pow(int'(rc), int'(rd), nn);
            run_op(rc, rd, W'(nn), 0, p, e, lat, bcnt, dones);
            check($sformatf("sweep_n%0d_c%0d_d%0d_plain", nn, rc, rd), p, exp_p);
            check($sformatf("sweep_n%0d_err", nn), e, 0);
            check($sformatf("sweep_n%0d_latency", nn), lat, LAT);
            check($sformatf("sweep_n%0d_busy_cycles", nn), bcnt, LAT);
            check($sformatf("sweep_n%0d_done_count", nn), dones, 1);
            exp_last = exp_p;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_decrypt.md
# rsa_decrypt

Decryption end of the 6-bit RSA datapath. It recovers plaintext M = C^D mod N from a ciphertext C produced by the encryption block, using the private exponent D. It uses left-to-right square-and-multiply with a sequential shift-subtract modular reducer and a fixed, data-independent latency. It sits beside the encryptor, shares its operand widths, and uses a level start / pulse done handshake.

## Interface
- W, default 6: operand width of cipher, key, modulus and result.
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- cipher  in  W  ciphertext C; captured when start is accepted.
- priv_key  in  W  private exponent D; captured when start is accepted.
- n  in  W  modulus N; captured when start is accepted.
- busy  out  1  high from the cycle after acceptance until the done cycle, inclusive.
- done  out  1  one-cycle pulse; plain is valid in that cycle.
- err  out  1  set with done when the captured N < 2.
- plain  out  W  result M; holds its value until the next done.

## Operation
- States: IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, FINISH.
- IDLE, start=1: capture C, D and N into registers. Set acc=1 and bit index i=W-1. Go to SQ_ISSUE.
  - If N<2, go directly to FINISH with err=1 and plain=0.
- SQ_ISSUE: launch reducer on acc*acc (2W-bit product, zero-extended) mod N. Go to SQ_WAIT.
- SQ_WAIT: wait for reducer done, then acc <= remainder. Go to MUL_ISSUE.
- MUL_ISSUE: always launch reducer on acc*C mod N (constant time). Go to MUL_WAIT.
- MUL_WAIT: on reducer done:
  - Write the remainder into acc only if D[i]=1.
  - If i==0, go to FINISH. Otherwise decrement i and go to SQ_ISSUE.
- FINISH: plain <= acc, done=1, busy=1. Go to IDLE.
- C ≥ N is legal. The first multiply reduces it, so the result is correct without pre-reduction.
- D=0 gives plain=1 (for N≥2).
- start while busy is ignored. Inputs are not resampled mid-operation.
- Arithmetic: product width 2W. Reducer remainder is always < N. No overflow is possible because acc < N ≤ 2^W−1.

## Timing
- Reset values: done=0, err=0, busy=0, plain=0, state=IDLE, reducer idle.
- Reducer: restoring shift-subtract, one product bit per cycle. Its result is valid exactly 2W cycles after launch.
- Each modmul (issue + wait) takes 2W+1 cycles, i.e. 13 cycles for W=6.
- Latency, measured from the edge that accepts start to the edge that raises done:
  - General: 1 + 2W(2W+1).
  - W=6: 157 cycles.
  - N<2 fast path: 1 cycle.
- Back-to-back: start held high in the done cycle's following IDLE is accepted. The minimum start-to-start spacing is latency+1.
- reset_n low mid-operation clears immediately: no done pulse, and plain returns to 0.
- err clears at the next acceptance.

## Structure
- Package rsa_pkg holds:
  - the W default;
  - the state enumeration typedef;
  - the latency constant LAT = 1 + 2*W*(2*W+1), for bench use.
- Sub-module mod_reduce:
  - Ports: clk, reset_n, go, dividend[2W], modulus[W], done, rem[W].
  - Fixed 2W-cycle sequential reducer.
  - Reusable by the encryptor later.
- The top-level instantiates exactly one mod_reduce and one W×W combinational multiplier. The multiplier operand mux selects acc or C.

## Test plan
- N=33, D=7, C=31 → plain=4 after exactly 157 cycles, with err=0. This is the inverse of encrypt(4, e=3).
- N=33, D=0, C=20 → plain=1. C=40, D=1, N=33 → plain=7 (C ≥ N case).
- N=1, any C and D → done and err high 1 cycle after acceptance, with plain=0.
- Second start pulse at cycle 50 of a run → ignored. Exactly one done at cycle 157, with the first run's result.
- reset_n low at cycle 80 → all outputs 0 asynchronously. A new start after release completes correctly (N=33, D=7, C=31 → 4).
- Exhaustive sweep for W=6: every N in 2..63, with random C and D. Compare against a software model; busy must be high exactly LAT cycles per run.
